// File: rtl/trdb_packet_sched.sv
// Packet scheduler: arbitrates trace, periodic resync and software requests into a
// single registered output slot with a valid/ready handshake and loss accounting.
module trdb_packet_sched #(
    parameter int PAYLOAD_W = 64,
    parameter int CNT_W     = 16,
    parameter int LOST_W    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 instr_valid_i,
    input  logic [CNT_W-1:0]     resync_period_i,
    input  logic [PAYLOAD_W-1:0] resync_payload_i,
    input  logic                 trace_valid_i,
    input  logic [1:0]           trace_format_i,
    input  logic [1:0]           trace_subformat_i,
    input  logic [PAYLOAD_W-1:0] trace_payload_i,
    input  logic                 sw_valid_i,
    input  logic [PAYLOAD_W-1:0] sw_payload_i,
    output logic                 sw_ready_o,
    output logic                 pkt_valid_o,
    input  logic                 pkt_ready_i,
    output logic [1:0]           pkt_format_o,
    output logic [1:0]           pkt_subformat_o,
    output logic [PAYLOAD_W-1:0] pkt_payload_o,
    output logic [1:0]           pkt_src_o,
    output logic [LOST_W-1:0]    lost_cnt_o,
    output logic                 overflow_o
);

    localparam logic [1:0] F_ADDR_ONLY = 2'h2;
    localparam logic [1:0] F_SYNC      = 2'h3;
    localparam logic [1:0] SF_START    = 2'h0;
    localparam logic [1:0] SF_CONTEXT  = 2'h2;
    localparam logic [1:0] SF_UNDEF    = 2'h3;

    localparam logic [1:0] SRC_TRACE  = 2'd0;
    localparam logic [1:0] SRC_RESYNC = 2'd1;
    localparam logic [1:0] SRC_SW     = 2'd2;

    typedef enum logic {EMPTY, FULL} slot_state_t;

    slot_state_t        state, state_next;
    logic               slot_free;
    logic               load_trace, load_resync, load_sw, load_any;
    logic               sync_load, trace_drop;
    logic               resync_pending, pending_next;
    logic [CNT_W-1:0]   resync_cnt, cnt_next;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= EMPTY;
        else         state <= state_next;
    end

    // Arbitration: an unstallable trace request always wins, then resync, then software.
    always_comb begin
        state_next  = state;
        slot_free   = (state == EMPTY) || pkt_ready_i;
        load_trace  = enable_i && slot_free && trace_valid_i;
        load_resync = enable_i && slot_free && !trace_valid_i && resync_pending;
        sw_ready_o  = enable_i && slot_free && !trace_valid_i && !resync_pending;
        load_sw     = sw_ready_o && sw_valid_i;
        load_any    = load_trace || load_resync || load_sw;
        trace_drop  = enable_i && trace_valid_i && !slot_free;
        sync_load   = load_resync || load_sw || (load_trace && (trace_format_i == F_SYNC));
        case (state)
            EMPTY:   if (load_any) state_next = FULL;
            FULL:    if (pkt_ready_i && !load_any) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    assign pkt_valid_o = (state == FULL);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_format_o    <= F_ADDR_ONLY;
            pkt_subformat_o <= SF_UNDEF;
            pkt_payload_o   <= '0;
            pkt_src_o       <= SRC_TRACE;
        end else if (load_trace) begin
            pkt_format_o    <= trace_format_i;
            pkt_subformat_o <= trace_subformat_i;
            pkt_payload_o   <= trace_payload_i;
            pkt_src_o       <= SRC_TRACE;
        end else if (load_resync) begin
            pkt_format_o    <= F_SYNC;
            pkt_subformat_o <= SF_START;
            pkt_payload_o   <= resync_payload_i;
            pkt_src_o       <= SRC_RESYNC;
        end else if (load_sw) begin
            pkt_format_o    <= F_SYNC;
            pkt_subformat_o <= SF_CONTEXT;
            pkt_payload_o   <= sw_payload_i;
            pkt_src_o       <= SRC_SW;
        end
    end

    // The counter parks at the period until a sync packet restarts it; a drop always re-arms.
    always_comb begin
        cnt_next     = resync_cnt;
        pending_next = resync_pending;
        if (!enable_i) begin
            cnt_next     = '0;
            pending_next = 1'b0;
        end else begin
            if (sync_load) begin
                cnt_next     = '0;
                pending_next = 1'b0;
            end else if (instr_valid_i && (resync_period_i != '0) && (resync_cnt < resync_period_i)) begin
                cnt_next = resync_cnt + 1'b1;
            end
            if (!sync_load && (resync_period_i != '0) && (cnt_next >= resync_period_i))
                pending_next = 1'b1;
            if (trace_drop)
                pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resync_cnt     <= '0;
            resync_pending <= 1'b0;
            lost_cnt_o     <= '0;
            overflow_o     <= 1'b0;
        end else begin
            resync_cnt     <= cnt_next;
            resync_pending <= pending_next;
            if (!enable_i) begin
                lost_cnt_o <= '0;
                overflow_o <= 1'b0;
            end else if (trace_drop) begin
                overflow_o <= 1'b1;
                if (lost_cnt_o != '1) lost_cnt_o <= lost_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trdb_packet_sched.sv
// Directed self-checking bench for trdb_packet_sched: a vector table for the basic
// arbitration/handshake cases plus hand sequences for drops, resync, saturation and reset.
module tb_trdb_packet_sched;

    localparam logic [1:0] F_BRANCH_FULL = 2'h0;
    localparam logic [1:0] F_BRANCH_DIFF = 2'h1;
    localparam logic [1:0] F_ADDR_ONLY   = 2'h2;
    localparam logic [1:0] F_SYNC        = 2'h3;
    localparam logic [1:0] SF_START      = 2'h0;
    localparam logic [1:0] SF_CONTEXT    = 2'h2;
    localparam logic [1:0] SF_UNDEF      = 2'h3;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        enable_i;
    logic        instr_valid_i;
    logic [15:0] resync_period_i;
    logic [63:0] resync_payload_i;
    logic        trace_valid_i;
    logic [1:0]  trace_format_i;
    logic [1:0]  trace_subformat_i;
    logic [63:0] trace_payload_i;
    logic        sw_valid_i;
    logic [63:0] sw_payload_i;
    logic        sw_ready_o;
    logic        pkt_valid_o;
    logic        pkt_ready_i;
    logic [1:0]  pkt_format_o;
    logic [1:0]  pkt_subformat_o;
    logic [63:0] pkt_payload_o;
    logic [1:0]  pkt_src_o;
    logic [7:0]  lost_cnt_o;
    logic        overflow_o;

    int checks = 0;
    int errors = 0;

    trdb_packet_sched dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
        .instr_valid_i(instr_valid_i), .resync_period_i(resync_period_i),
        .resync_payload_i(resync_payload_i), .trace_valid_i(trace_valid_i),
        .trace_format_i(trace_format_i), .trace_subformat_i(trace_subformat_i),
        .trace_payload_i(trace_payload_i), .sw_valid_i(sw_valid_i),
        .sw_payload_i(sw_payload_i), .sw_ready_o(sw_ready_o),
        .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
        .pkt_format_o(pkt_format_o), .pkt_subformat_o(pkt_subformat_o),
        .pkt_payload_o(pkt_payload_o), .pkt_src_o(pkt_src_o),
        .lost_cnt_o(lost_cnt_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic        tv;
        logic [1:0]  tf, ts;
        logic [63:0] tp;
        logic        sv;
        logic [63:0] sp;
        logic        rdy;
        logic        e_swr;
        logic        e_val;
        logic [1:0]  e_fmt, e_sub, e_src;
        logic [63:0] e_pay;
        logic [7:0]  e_lost;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(logic tv, logic [1:0] tf, logic [1:0] ts, logic [63:0] tp,
                                logic sv, logic [63:0] sp, logic rdy, logic e_swr,
                                logic e_val, logic [1:0] e_fmt, logic [1:0] e_sub,
                                logic [1:0] e_src, logic [63:0] e_pay, logic [7:0] e_lost);
        vec_t v;
        v.tv = tv; v.tf = tf; v.ts = ts; v.tp = tp; v.sv = sv; v.sp = sp; v.rdy = rdy;
        v.e_swr = e_swr; v.e_val = e_val; v.e_fmt = e_fmt; v.e_sub = e_sub;
        v.e_src = e_src; v.e_pay = e_pay; v.e_lost = e_lost;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkPacket(input string tag, input logic [1:0] fmt, input logic [1:0] sub,
                               input logic [1:0] src, input logic [63:0] pay);
        checkOutput({tag, " valid"}, 64'(pkt_valid_o), 64'd1);
        checkOutput({tag, " format"}, 64'(pkt_format_o), 64'(fmt));
        checkOutput({tag, " subformat"}, 64'(pkt_subformat_o), 64'(sub));
        checkOutput({tag, " src"}, 64'(pkt_src_o), 64'(src));
        checkOutput({tag, " payload"}, pkt_payload_o, pay);
    endtask

    task automatic idleInputs();
        trace_valid_i = 1'b0;
        sw_valid_i    = 1'b0;
        instr_valid_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        trace_valid_i     = v.tv;
        trace_format_i    = v.tf;
        trace_subformat_i = v.ts;
        trace_payload_i   = v.tp;
        sw_valid_i        = v.sv;
        sw_payload_i      = v.sp;
        pkt_ready_i       = v.rdy;
        #1;
        checkOutput("vec sw_ready", 64'(sw_ready_o), 64'(v.e_swr));
        tick();
        checkOutput("vec valid", 64'(pkt_valid_o), 64'(v.e_val));
        if (v.e_val) checkPacket("vec pkt", v.e_fmt, v.e_sub, v.e_src, v.e_pay);
        checkOutput("vec lost", 64'(lost_cnt_o), 64'(v.e_lost));
        checkOutput("vec overflow", 64'(overflow_o), 64'(v.e_lost != 0));
    endtask

    initial begin
        vecs[0]  = mk(1, F_BRANCH_FULL, 0, 64'h1000, 0, 0,          1, 0, 1, F_BRANCH_FULL, 0, 0, 64'h1000, 0);
        vecs[1]  = mk(0, 0, 0, 0,                    0, 0,          1, 1, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0,                    1, 64'hABCD,   0, 1, 1, F_SYNC, SF_CONTEXT, 2, 64'hABCD, 0);
        vecs[3]  = mk(0, 0, 0, 0,                    1, 64'h5555,   0, 0, 1, F_SYNC, SF_CONTEXT, 2, 64'hABCD, 0);
        vecs[4]  = mk(1, F_ADDR_ONLY, 1, 64'h2222,   1, 64'h5555,   1, 0, 1, F_ADDR_ONLY, 1, 0, 64'h2222, 0);
        vecs[5]  = mk(0, 0, 0, 0,                    1, 64'h7777,   1, 1, 1, F_SYNC, SF_CONTEXT, 2, 64'h7777, 0);
        vecs[6]  = mk(0, 0, 0, 0,                    0, 0,          1, 1, 0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(1, F_BRANCH_DIFF, 0, 64'h3333, 0, 0,          0, 0, 1, F_BRANCH_DIFF, 0, 0, 64'h3333, 0);
        vecs[8]  = mk(1, F_BRANCH_FULL, 0, 64'h4444, 0, 0,          0, 0, 1, F_BRANCH_DIFF, 0, 0, 64'h3333, 1);
        vecs[9]  = mk(0, 0, 0, 0,                    0, 0,          1, 0, 1, F_SYNC, SF_START, 1, 64'hCAFE, 1);
        vecs[10] = mk(0, 0, 0, 0,                    1, 64'h8888,   1, 1, 1, F_SYNC, SF_CONTEXT, 2, 64'h8888, 1);
        vecs[11] = mk(0, 0, 0, 0,                    0, 0,          1, 1, 0, 0, 0, 0, 0, 1);

        rst_ni = 1'b0;
        enable_i = 1'b0;
        idleInputs();
        resync_period_i   = 16'd0;
        resync_payload_i  = 64'hCAFE;
        trace_format_i    = 2'd0;
        trace_subformat_i = 2'd0;
        trace_payload_i   = 64'd0;
        sw_payload_i      = 64'd0;
        pkt_ready_i       = 1'b0;
        tick();
        tick();

        checkOutput("reset valid", 64'(pkt_valid_o), 64'd0);
        checkOutput("reset format", 64'(pkt_format_o), 64'(F_ADDR_ONLY));
        checkOutput("reset subformat", 64'(pkt_subformat_o), 64'(SF_UNDEF));
        checkOutput("reset src", 64'(pkt_src_o), 64'd0);
        checkOutput("reset payload", pkt_payload_o, 64'd0);
        checkOutput("reset lost", 64'(lost_cnt_o), 64'd0);
        checkOutput("reset overflow", 64'(overflow_o), 64'd0);
        checkOutput("reset sw_ready", 64'(sw_ready_o), 64'd0);

        rst_ni = 1'b1;
        enable_i = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

        // Three drops against a stalled slot, then the forced resync.
        idleInputs();
        enable_i = 1'b0;
        tick();
        checkOutput("disable lost", 64'(lost_cnt_o), 64'd0);
        checkOutput("disable overflow", 64'(overflow_o), 64'd0);
        enable_i = 1'b1;
        pkt_ready_i = 1'b0;
        trace_valid_i = 1'b1;
        trace_format_i = F_BRANCH_FULL;
        trace_subformat_i = 2'd0;
        trace_payload_i = 64'h9000;
        tick();
        for (int i = 0; i < 3; i++) begin
            trace_payload_i = 64'h9100 + 64'(i);
            tick();
        end
        trace_valid_i = 1'b0;
        checkOutput("drop3 lost", 64'(lost_cnt_o), 64'd3);
        checkOutput("drop3 overflow", 64'(overflow_o), 64'd1);
        checkPacket("drop3 held", F_BRANCH_FULL, 2'd0, 2'd0, 64'h9000);
        pkt_ready_i = 1'b1;
        #1;
        checkOutput("drop3 sw_ready", 64'(sw_ready_o), 64'd0);
        tick();
        checkPacket("drop3 resync", F_SYNC, SF_START, 2'd1, 64'hCAFE);
        tick();
        checkOutput("drop3 drained", 64'(pkt_valid_o), 64'd0);

        // Periodic resync every 4 instructions.
        enable_i = 1'b0;
        tick();
        enable_i = 1'b1;
        resync_period_i = 16'd4;
        resync_payload_i = 64'h1234;
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < 4; i++) begin
                instr_valid_i = 1'b1;
                tick();
                checkOutput("period early", 64'(pkt_valid_o), 64'd0);
            end
            instr_valid_i = 1'b0;
            tick();
            checkPacket("period resync", F_SYNC, SF_START, 2'd1, 64'h1234);
            tick();
            checkOutput("period drained", 64'(pkt_valid_o), 64'd0);
        end

        // Trace, pending resync and software all competing in one cycle.
        resync_period_i = 16'd1;
        instr_valid_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        resync_period_i = 16'd0;
        trace_valid_i = 1'b1;
        trace_format_i = F_BRANCH_FULL;
        trace_payload_i = 64'hAAAA;
        sw_valid_i = 1'b1;
        sw_payload_i = 64'hBBBB;
        #1;
        checkOutput("contend sw_ready t", 64'(sw_ready_o), 64'd0);
        tick();
        checkPacket("contend trace", F_BRANCH_FULL, 2'd0, 2'd0, 64'hAAAA);
        trace_valid_i = 1'b0;
        #1;
        checkOutput("contend sw_ready r", 64'(sw_ready_o), 64'd0);
        tick();
        checkPacket("contend resync", F_SYNC, SF_START, 2'd1, 64'h1234);
        #1;
        checkOutput("contend sw_ready s", 64'(sw_ready_o), 64'd1);
        tick();
        checkPacket("contend sw", F_SYNC, SF_CONTEXT, 2'd2, 64'hBBBB);
        sw_valid_i = 1'b0;
        tick();
        checkOutput("contend drained", 64'(pkt_valid_o), 64'd0);

        // Saturate the lost counter, then flush it with enable low.
        pkt_ready_i = 1'b0;
        trace_valid_i = 1'b1;
        trace_payload_i = 64'hD000;
        tick();
        trace_payload_i = 64'hD001;
        for (int i = 0; i < 300; i++) tick();
        trace_valid_i = 1'b0;
        checkOutput("sat lost", 64'(lost_cnt_o), 64'd255);
        checkOutput("sat overflow", 64'(overflow_o), 64'd1);
        checkOutput("sat held payload", pkt_payload_o, 64'hD000);
        enable_i = 1'b0;
        trace_valid_i = 1'b1;
        #1;
        checkOutput("sat sw_ready off", 64'(sw_ready_o), 64'd0);
        tick();
        trace_valid_i = 1'b0;
        checkOutput("flush lost", 64'(lost_cnt_o), 64'd0);
        checkOutput("flush overflow", 64'(overflow_o), 64'd0);
        checkPacket("flush slot kept", F_BRANCH_FULL, 2'd0, 2'd0, 64'hD000);

        // Asynchronous reset with a stalled packet in the slot.
        enable_i = 1'b1;
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("async reset valid", 64'(pkt_valid_o), 64'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        pkt_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("post reset no stale", 64'(pkt_valid_o), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
